fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
Instruction-fetch sequencer that owns the PC and drives the combinational instruction memory address (im_addr -> instr, word index = (addr - IM_BASE)[11:2]).
Buffers fetched words in a small FIFO and hands {pc, instr} to decode over a valid/ready handshake.
Accepts branch/jump/exception redirects that flush in-flight fetches.
Sits between the instruction memory and the decode stage of the CPU pipeline.

Parameters:
RESET_PC, 32'h00003000, PC loaded on reset.
IM_BASE, 32'h00003000, byte address of instruction memory word 0.
IM_WORDS, 1024, instruction memory depth in words.
DEPTH, 2, fetch queue entries (power of two, >=2).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
im_addr  output  32  byte address to instruction memory; equals the pc register.
im_instr  input  32  combinational instruction read for im_addr, same cycle.
redirect_valid  input  1  load new PC and flush queue this cycle.
redirect_pc  input  32  target PC for redirect.
out_valid  output  1  queue head holds a valid entry.
out_ready  input  1  decode accepts head this cycle.
out_pc  output  32  PC of head entry.
out_instr  output  32  instruction of head entry.
out_fault  output  1  head entry is a fetch fault (FETCH_FAULT_EN only; else tied 0).

Behaviour:
- Reset, synchronous and active-high, on clk:
  - pc = RESET_PC; queue count = 0; state = RUN.
  - out_valid = 0; out_pc = 0; out_instr = 0; out_fault = 0.
  - Reset mid-operation discards all entries in the same edge.
- FSM states:
  - RUN: fetching.
  - HALT: fault entry issued; fetch stopped. Reachable only with FETCH_FAULT_EN.
- pop = out_valid & out_ready.
- push = (state==RUN) & !redirect_valid & (count<DEPTH | pop).
- On push: enqueue {pc, im_instr, fault=0}; pc <= pc + 4, modulo 2^32.
- Push and pop in the same cycle are both performed.
  - When full, count is unchanged.
  - When empty, pop is impossible (out_valid=0).
- Queue full and no pop: pc holds, im_addr stable, no enqueue.
- Redirect has top priority:
  - count <= 0; pc <= redirect_pc; state <= RUN.
  - No push that cycle. A simultaneous pop is accepted by decode but the entry is discarded by the flush.
- Latency:
  - First entry is valid in the cycle after reset deasserts (out_pc = RESET_PC).
  - After a redirect in cycle N, out_valid = 0 in N+1; the target entry is valid in N+2.
- Throughput: one instruction per cycle while out_ready is held high.
- Outputs come from registered queue storage; no combinational path from im_instr to out_*.
- Without FETCH_FAULT_EN, out-of-range PCs are fetched as-is; the memory aliases on index bits.

Optional Feature:
Macro: FETCH_FAULT_EN.
- Defined: at a push, if pc[1:0] != 0 or pc < IM_BASE or pc >= IM_BASE + 4*IM_WORDS:
  - enqueue {pc, 32'h0, fault=1} instead of the fetched word;
  - pc holds; state <= HALT.
- In HALT: no pushes. Only a redirect or reset leaves HALT.
- Entries enqueued before the fault still drain in order.
- Not defined: no range/alignment check; out_fault = 0 constant; HALT state absent.

Decomposition:
- Shared package fetch_pkg holds:
  - RESET_PC, IM_BASE, IM_WORDS constants;
  - fetch-entry typedef {pc[31:0], instr[31:0], fault};
  - FSM state encoding (RUN=0, HALT=1).
- One sub-module, fetch_queue: DEPTH-entry synchronous FIFO with push/pop/flush, count, and head outputs.
- fetch_seq holds the PC register, FSM, push/pop logic and fault check.

Test Plan:
1. Reset, then out_ready=1 for 4 cycles -> out_pc = 0x3000, 0x3004, 0x3008, 0x300C in consecutive cycles; out_instr matches memory words 0..3.
2. out_ready=0 after reset for 5 cycles -> count saturates at 2; im_addr holds at 0x3008; releasing out_ready yields 0x3000, 0x3004, 0x3008 with no gap or loss.
3. redirect_valid=1, redirect_pc=0x3040 in cycle N with the queue full and a pop in N -> out_valid=0 in N+1; out_pc=0x3040 in N+2; entries 0x3004/0x3008 never appear.
4. reset asserted while the queue holds 2 entries -> next cycle out_valid=0 and im_addr=0x3000; fetch restarts from 0x3000.
5. With FETCH_FAULT_EN, redirect to 0x00004000 -> one entry with out_fault=1, out_pc=0x4000, out_instr=0; FSM stays in HALT until redirect to 0x3000 resumes normal fetch.
6. With FETCH_FAULT_EN, redirect to 0x3002 -> fault entry with out_pc=0x3002; without the macro, out_pc=0x3002, then 0x3006, with out_fault=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The fault check compiled in by FETCH_FAULT_EN uses in_im_range().
package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int unsigned IM_WORDS = 1024;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // The comparison is done at 33 bits so that IM_BASE + 4*IM_WORDS cannot wrap.
    function automatic logic in_im_range(input logic [31:0] addr);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, IM_BASE};
        hi = lo + 33'(4 * IM_WORDS);
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Instruction-memory, redirect and decode-handshake signals of fetch_seq.
// The master side is the sequencer; the slave side is memory, redirect source and decode.
interface fetch_seq_if;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;

    modport master (
        output im_addr,
        input  im_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output out_fault
    );

    modport slave (
        input  im_addr,
        output im_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  out_fault
    );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; the head is read from registered storage.
// The caller guarantees no push into a full queue without a pop, and no pop from an empty one.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t push_entry_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 1'b1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // When full with a simultaneous pop, the write lands in the slot being vacated.
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, fetches into fetch_queue, hands {pc, instr} to decode.
// Define FETCH_FAULT_EN to enable the alignment/range fault check and the HALT state.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_RUN  | fetching one word per cycle while queue has room
//   ST_HALT | fault entry issued; fetch stopped until redirect
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    fetch_seq_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q;
    fetch_state_e  state_q;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          out_valid;
    logic          pop;
    logic          push;
    logic          fault;

    assign out_valid = (count != '0);
    assign pop       = out_valid & bus.out_ready;
    assign push      = (state_q == ST_RUN) & ~bus.redirect_valid
                       & ((count < CW'(DEPTH)) | pop);

`ifdef FETCH_FAULT_EN
    assign fault = (pc_q[1:0] != 2'b00) | ~in_im_range(pc_q);
`else
    assign fault = 1'b0;
`endif

    always_comb begin
        push_entry.pc    = pc_q;
        push_entry.instr = fault ? 32'h0 : bus.im_instr;
        push_entry.fault = fault;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
        end else if (bus.redirect_valid) begin
            pc_q    <= bus.redirect_pc;
            state_q <= ST_RUN;
        end else if (push) begin
`ifdef FETCH_FAULT_EN
            if (fault) begin
                state_q <= ST_HALT;
            end else begin
                pc_q <= pc_q + 32'd4;
            end
`else
            pc_q <= pc_q + 32'd4;
`endif
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (bus.redirect_valid),
        .push_i       (push),
        .pop_i        (pop),
        .push_entry_i (push_entry),
        .count_o      (count),
        .head_o       (head)
    );

    // Without the fault check, stored fault bits are only ever written as 0.
    assign bus.im_addr   = pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign bus.out_fault = head.fault;

endmodule

// File: tb/tb_fetch_seq.sv
// Table-driven bench for fetch_seq: one row per cycle with inputs and the outputs visible in that cycle.
// Expected values follow FETCH_FAULT_EN when the macro is defined.
module tb_fetch_seq;
    import fetch_pkg::*;

`ifdef FETCH_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        eflt;
        logic [31:0] eaddr;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    fetch_seq_if bus ();

    fetch_seq #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        logic [31:0] off;
        logic [9:0]  idx;
        off = addr - IM_BASE;
        idx = off[11:2];
        return 32'hB000_0000 + 32'(idx) * 32'h0001_0001;
    endfunction

    assign bus.im_instr = word_at(bus.im_addr);

    function automatic vec_t v(input logic rst, input logic rv, input logic [31:0] rpc,
                               input logic rdy, input logic ev, input logic [31:0] epc,
                               input logic eflt, input logic [31:0] eaddr);
        vec_t r;
        r.rst = rst; r.rv = rv; r.rpc = rpc; r.rdy = rdy;
        r.ev = ev; r.epc = epc; r.eflt = eflt; r.eaddr = eaddr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;

        // linear fetch with out_ready high
        vecs.push_back(v(0, 0, 0, 1, 0, 0,          0, 32'h3000));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3000,   0, 32'h3004));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3004,   0, 32'h3008));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3008,   0, 32'h300C));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h300C,   0, 32'h3010));
        // reset, then stall until full, then drain
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h3010,   0, 32'h3014));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,          0, 32'h3000));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h3000,   0, 32'h3004));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h3000,   0, 32'h3008));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h3000,   0, 32'h3008));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h3000,   0, 32'h3008));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3000,   0, 32'h3008));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3004,   0, 32'h300C));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3008,   0, 32'h3010));
        // full queue, redirect with simultaneous pop
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h300C,   0, 32'h3014));
        vecs.push_back(v(0, 1, 32'h3040, 1, 1, 32'h300C, 0, 32'h3014));
        vecs.push_back(v(0, 0, 0, 1, 0, 0,          0, 32'h3040));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3040,   0, 32'h3044));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3044,   0, 32'h3048));
        // reset with two entries held
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h3048,   0, 32'h304C));
        vecs.push_back(v(1, 0, 0, 0, 1, 32'h3048,   0, 32'h3050));
        vecs.push_back(v(0, 0, 0, 1, 0, 0,          0, 32'h3000));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3000,   0, 32'h3004));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3004,   0, 32'h3008));
        // misaligned redirect
        vecs.push_back(v(0, 1, 32'h3002, 1, 1, 32'h3008, 0, 32'h300C));
        vecs.push_back(v(0, 0, 0, 1, 0, 0,          0, 32'h3002));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3002,   FE, FE ? 32'h3002 : 32'h3006));
        vecs.push_back(v(0, 0, 0, 1, !FE, FE ? 32'h0 : 32'h3006, 0, FE ? 32'h3002 : 32'h300A));
        // out-of-range redirect (aliases to word 0 without the fault check)
        vecs.push_back(v(0, 1, 32'h4000, 1, !FE, FE ? 32'h0 : 32'h300A, 0, FE ? 32'h3002 : 32'h300E));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,          0, 32'h4000));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h4000,   FE, FE ? 32'h4000 : 32'h4004));
        vecs.push_back(v(0, 0, 0, 0, 1, 32'h4000,   FE, FE ? 32'h4000 : 32'h4008));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h4000,   FE, FE ? 32'h4000 : 32'h4008));
        vecs.push_back(v(0, 0, 0, 0, !FE, FE ? 32'h0 : 32'h4004, 0, FE ? 32'h4000 : 32'h400C));
        vecs.push_back(v(0, 1, 32'h3000, 1, !FE, FE ? 32'h0 : 32'h4004, 0, FE ? 32'h4000 : 32'h400C));
        vecs.push_back(v(0, 0, 0, 1, 0, 0,          0, 32'h3000));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3000,   0, 32'h3004));
        vecs.push_back(v(0, 0, 0, 1, 1, 32'h3004,   0, 32'h3008));

        // reset state after two reset edges
        repeat (2) @(negedge clk);
        #1;
        chk("reset_valid", 32'(bus.out_valid), 32'h0);
        chk("reset_pc",    bus.out_pc,         32'h0);
        chk("reset_instr", bus.out_instr,      32'h0);
        chk("reset_fault", 32'(bus.out_fault), 32'h0);
        chk("reset_addr",  bus.im_addr,        RESET_PC);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            reset              = vecs[i].rst;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc    = vecs[i].rpc;
            bus.out_ready      = vecs[i].rdy;
            #1;
            chk($sformatf("c%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
            chk($sformatf("c%0d_addr", i),  bus.im_addr,        vecs[i].eaddr);
            if (vecs[i].ev) begin
                chk($sformatf("c%0d_pc", i),    bus.out_pc, vecs[i].epc);
                chk($sformatf("c%0d_instr", i), bus.out_instr,
                    vecs[i].eflt ? 32'h0 : word_at(vecs[i].epc));
                chk($sformatf("c%0d_fault", i), 32'(bus.out_fault), 32'(vecs[i].eflt));
            end
            @(negedge clk);
        end

        // sustained one-per-cycle throughput with out_ready held high
        reset              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("tp%0d_valid", k), 32'(bus.out_valid), 32'h1);
            chk($sformatf("tp%0d_pc", k),    bus.out_pc,    32'h3008 + 32'(4 * k));
            chk($sformatf("tp%0d_instr", k), bus.out_instr, word_at(32'h3008 + 32'(4 * k)));
            chk($sformatf("tp%0d_addr", k),  bus.im_addr,   32'h300C + 32'(4 * k));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
